gpio_irq_ctrl: RTL and testbench



---
 rtl/gpio_irq_ctrl.sv | 110 +++++++++++
 tb/tb_gpio_irq_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/gpio_irq_ctrl.sv
// rtl/gpio_irq_ctrl.sv - GPIO synchroniser, debounce filter and sticky interrupt controller
module gpio_irq_ctrl #(
    parameter int N_CH        = 8,
    parameter int DEBOUNCE_W  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    sys_clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         gpio_i,
    input  logic [DEBOUNCE_W-1:0]   debounce_limit,
    input  logic [2*N_CH-1:0]       irq_mode,
    input  logic [N_CH-1:0]         irq_en,
    input  logic [N_CH-1:0]         irq_clr,
    output logic [N_CH-1:0]         gpio_filt,
    output logic [N_CH-1:0]         irq_pending,
    output logic                    irq_o
);

    localparam logic [1:0] MODE_RISE  = 2'b00;
    localparam logic [1:0] MODE_FALL  = 2'b01;
    localparam logic [1:0] MODE_BOTH  = 2'b10;

    logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
    logic [N_CH-1:0]                  sync;
    logic [DEBOUNCE_W-1:0]            cnt_q [N_CH];
    logic [DEBOUNCE_W-1:0]            cnt_d [N_CH];
    logic [N_CH-1:0]                  gpio_filt_q, gpio_filt_d;
    logic [N_CH-1:0]                  filt_q;
    logic [N_CH-1:0]                  rise, fall, evt;
    logic [N_CH-1:0]                  pending_q, pending_d;
    logic                             irq_q, irq_d;

    assign sync = sync_q[SYNC_STAGES-1];

    // Synchroniser chain: stage 0 samples the pads, the last stage feeds the debouncer.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_i};
        end
    end

    // Debounce: a mismatch must survive debounce_limit+1 cycles; the >= compare
    // keeps the counter from running past the limit, so it never wraps.
    always_comb begin
        gpio_filt_d = gpio_filt_q;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync[i] == gpio_filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= debounce_limit) begin
                gpio_filt_d[i] = sync[i];
                cnt_d[i]       = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + DEBOUNCE_W'(1);
            end
        end
    end

    // Debounce state and the one-cycle-delayed copy used for edge detection.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            gpio_filt_q <= '0;
            filt_q      <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            gpio_filt_q <= gpio_filt_d;
            filt_q      <= gpio_filt_q;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Event selection per channel mode; set beats clear so no event is lost.
    always_comb begin
        rise = gpio_filt_q & ~filt_q;
        fall = ~gpio_filt_q & filt_q;
        evt  = '0;
        for (int i = 0; i < N_CH; i++) begin
            case (irq_mode[2*i +: 2])
                MODE_RISE: evt[i] = rise[i];
                MODE_FALL: evt[i] = fall[i];
                MODE_BOTH: evt[i] = rise[i] | fall[i];
                default:   evt[i] = gpio_filt_q[i];
            endcase
        end
        pending_d = (pending_q & ~irq_clr) | (evt & irq_en);
        irq_d     = |(pending_q & irq_en);
    end

    // Sticky pending flags and the registered aggregate request.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            irq_q     <= irq_d;
        end
    end

    assign gpio_filt   = gpio_filt_q;
    assign irq_pending = pending_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// tb/tb_gpio_irq_ctrl.sv - directed vector bench for gpio_irq_ctrl
module tb_gpio_irq_ctrl;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic [7:0]  gpio_i;
    logic [15:0] debounce_limit;
    logic [15:0] irq_mode;
    logic [7:0]  irq_en;
    logic [7:0]  irq_clr;
    logic [7:0]  gpio_filt;
    logic [7:0]  irq_pending;
    logic        irq_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] gpio;
        logic [7:0] clr;
        logic [7:0] filt;
        logic [7:0] pend;
        logic       irq;
    } vec_t;

    vec_t tbl[$];

    gpio_irq_ctrl #(.N_CH(8), .DEBOUNCE_W(16), .SYNC_STAGES(2)) dut (
        .sys_clk        (sys_clk),
        .rst            (rst),
        .gpio_i         (gpio_i),
        .debounce_limit (debounce_limit),
        .irq_mode       (irq_mode),
        .irq_en         (irq_en),
        .irq_clr        (irq_clr),
        .gpio_filt      (gpio_filt),
        .irq_pending    (irq_pending),
        .irq_o          (irq_o)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [7:0] f, input logic [7:0] p, input logic i);
        chk({name, ".filt"}, gpio_filt, f);
        chk({name, ".pend"}, irq_pending, p);
        chk({name, ".irq"}, {7'd0, irq_o}, {7'd0, i});
    endtask

    initial begin
        rst = 1'b1; gpio_i = '0; debounce_limit = 16'd3; irq_mode = '0;
        irq_en = 8'h03; irq_clr = '0;
        step(2);
        chk_all("reset", 8'h00, 8'h00, 1'b0);
        rst = 1'b0;

        // ch0 rising edge with limit 3, then clear; then a 3-cycle glitch on ch1
        for (int r = 0; r < 5; r++) tbl.push_back('{8'h01, 8'h00, 8'h00, 8'h00, 1'b0});
        tbl.push_back('{8'h01, 8'h00, 8'h01, 8'h00, 1'b0});
        tbl.push_back('{8'h01, 8'h00, 8'h01, 8'h01, 1'b0});
        tbl.push_back('{8'h01, 8'h00, 8'h01, 8'h01, 1'b1});
        tbl.push_back('{8'h01, 8'h01, 8'h01, 8'h00, 1'b1});
        tbl.push_back('{8'h01, 8'h00, 8'h01, 8'h00, 1'b0});
        for (int r = 0; r < 3; r++) tbl.push_back('{8'h03, 8'h00, 8'h01, 8'h00, 1'b0});
        for (int r = 0; r < 7; r++) tbl.push_back('{8'h01, 8'h00, 8'h01, 8'h00, 1'b0});

        for (int r = 0; r < tbl.size(); r++) begin
            gpio_i  = tbl[r].gpio;
            irq_clr = tbl[r].clr;
            step(1);
            chk_all($sformatf("vec%0d", r), tbl[r].filt, tbl[r].pend, tbl[r].irq);
        end
        irq_clr = '0;

        // Modes: ch2 falling, ch3 both, ch4 level, limit 0
        debounce_limit = 16'd0; irq_mode = 16'h0390; irq_en = 8'h1C;
        gpio_i = 8'h1D;
        step(3);
        chk("mode_rise_filt", gpio_filt, 8'h1D);
        chk("mode_rise_pend_early", irq_pending, 8'h00);
        step(1);
        chk("mode_rise_pend", irq_pending, 8'h18);
        irq_clr = 8'h1C; step(1); irq_clr = '0;
        chk("mode_clr_high", irq_pending, 8'h10);
        chk("mode_irq_high", {7'd0, irq_o}, 8'h01);
        step(15);
        chk("mode_level_hold", irq_pending, 8'h10);
        gpio_i = 8'h01;
        step(4);
        chk("mode_fall_filt", gpio_filt, 8'h01);
        chk("mode_fall_pend", irq_pending, 8'h1C);
        irq_clr = 8'h1C; step(1); irq_clr = '0;
        chk("mode_clr_low", irq_pending, 8'h00);
        step(1);
        chk("mode_irq_low", {7'd0, irq_o}, 8'h00);

        // Clear/set collision on ch0
        irq_mode = '0; irq_en = 8'h01;
        gpio_i = 8'h00; step(4);
        chk("coll_fall_no_pend", irq_pending, 8'h00);
        gpio_i = 8'h01; step(3);
        chk("coll_pre", irq_pending, 8'h00);
        irq_clr = 8'h01; step(1); irq_clr = '0;
        chk("coll_set_wins", irq_pending, 8'h01);
        step(1);
        chk("coll_irq", {7'd0, irq_o}, 8'h01);
        irq_clr = 8'h01; step(1); irq_clr = '0;
        chk("coll_idle_clr", irq_pending, 8'h00);
        chk("coll_irq_lag", {7'd0, irq_o}, 8'h01);
        step(1);
        chk("coll_irq_fall", {7'd0, irq_o}, 8'h00);

        // Enable gating on ch5
        irq_en = 8'h00; gpio_i = 8'h21; step(6);
        chk("en_off_filt", gpio_filt, 8'h21);
        chk("en_off_pend", irq_pending, 8'h00);
        irq_en = 8'h20; step(2);
        chk("en_late_pend", irq_pending, 8'h00);
        chk("en_late_irq", {7'd0, irq_o}, 8'h00);
        gpio_i = 8'h01; step(4);
        gpio_i = 8'h21; step(4);
        chk("en_on_pend", irq_pending, 8'h20);
        step(1);
        chk("en_on_irq", {7'd0, irq_o}, 8'h01);
        irq_en = 8'h00; step(1);
        chk("en_drop_pend", irq_pending, 8'h20);
        chk("en_drop_irq", {7'd0, irq_o}, 8'h00);

        // Async reset mid-operation, then release with ch6 held high
        irq_clr = 8'h20; step(1); irq_clr = '0;
        debounce_limit = 16'd3; irq_en = 8'h40; gpio_i = 8'h41;
        step(7);
        chk("rst_pre_pend", irq_pending, 8'h40);
        gpio_i = 8'hC1; step(3);
        #2; rst = 1'b1; #1;
        chk_all("rst_async", 8'h00, 8'h00, 1'b0);
        step(2);
        chk_all("rst_held", 8'h00, 8'h00, 1'b0);
        gpio_i = 8'h40; rst = 1'b0;
        step(6);
        chk("rst_rel_filt", gpio_filt, 8'h40);
        chk("rst_rel_pend_early", irq_pending, 8'h00);
        step(1);
        chk("rst_rel_pend", irq_pending, 8'h40);
        step(1);
        chk("rst_rel_irq", {7'd0, irq_o}, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
